// File: rtl/clock_pkg.sv
// Shared definitions for the clock monitor and the clock divider beside it.
package clock_pkg;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_TRACK  = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   localparam int DEF_THRESHOLD = 50000;

endpackage

// File: rtl/sync_edge.sv
// Three-flop synchronizer for the divided clock with rise/fall detection
// on the two settled stages.
module sync_edge (
   input  logic clksrc,
   input  logic rst_n,
   input  logic i_d,
   output logic o_rise,
   output logic o_fall
);

   logic r_s1, r_s2, r_s3;

   always_ff @(posedge clksrc or negedge rst_n) begin
      if (!rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= i_d;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign o_rise = r_s2 & ~r_s3;
   assign o_fall = ~r_s2 & r_s3;

endmodule

// File: rtl/clock_monitor.sv
// Measures each half-period of clk_in in clksrc cycles and tracks lock.
// CLOCK_MONITOR_PERIOD_EN enables the full-period measurement output.
import clock_pkg::*;

module clock_monitor #(
   parameter int THRESHOLD  = DEF_THRESHOLD,
   parameter int TOL        = 16,
   parameter int LOCK_COUNT = 4,
   parameter int CW         = 32
) (
   input  logic          clksrc,
   input  logic          rst_n,
   input  logic          clk_in,
   output logic          tick,
   output logic          locked,
   output logic          fault,
   output logic [CW-1:0] period
);

   localparam logic [CW-1:0] LO = CW'(THRESHOLD - TOL);
   localparam logic [CW-1:0] HI = CW'(THRESHOLD + TOL);
   localparam int            SW = $clog2(LOCK_COUNT + 1);
   localparam logic [SW-1:0] LOCK_N = SW'(LOCK_COUNT);

   state_t        r_state, w_next;
   logic [CW-1:0] r_hcount, w_hcount_nxt;
   logic [SW-1:0] r_streak, w_streak_nxt, w_streak_inc;
   logic          w_rise, w_fall, w_edge, w_good, w_stall, w_fault_nxt;
   logic          r_tick, r_locked, r_fault;

   sync_edge u_sync (
      .clksrc (clksrc),
      .rst_n  (rst_n),
      .i_d    (clk_in),
      .o_rise (w_rise),
      .o_fall (w_fall)
   );

   assign w_edge       = w_rise | w_fall;
   assign w_good       = (r_hcount >= LO) && (r_hcount <= HI);
   // an edge always wins over a stall in the same cycle
   assign w_stall      = !w_edge && (r_hcount == HI);
   assign w_streak_inc = r_streak + 1'b1;

   always_comb begin
      w_next       = r_state;
      w_streak_nxt = r_streak;
      w_fault_nxt  = 1'b0;
      case (r_state)
         ST_SEARCH: begin
            if (w_edge) begin
               w_next       = ST_TRACK;
               w_streak_nxt = '0;
            end
         end
         ST_TRACK: begin
            if (w_edge && w_good) begin
               w_streak_nxt = w_streak_inc;
               if (w_streak_inc == LOCK_N) w_next = ST_LOCKED;
            end else if (w_edge) begin
               w_streak_nxt = '0;
               w_fault_nxt  = 1'b1;
            end else if (w_stall) begin
               w_next       = ST_SEARCH;
               w_streak_nxt = '0;
               w_fault_nxt  = 1'b1;
            end
         end
         ST_LOCKED: begin
            if (w_edge && !w_good) begin
               w_next       = ST_TRACK;
               w_streak_nxt = '0;
               w_fault_nxt  = 1'b1;
            end else if (w_stall) begin
               w_next       = ST_SEARCH;
               w_streak_nxt = '0;
               w_fault_nxt  = 1'b1;
            end
         end
         default: w_next = ST_SEARCH;
      endcase
   end

   always_comb begin
      w_hcount_nxt = r_hcount + 1'b1;
      if (w_edge)                                 w_hcount_nxt = CW'(1);
      else if (r_state == ST_SEARCH || w_stall)   w_hcount_nxt = '0;
   end

   always_ff @(posedge clksrc or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_SEARCH;
         r_hcount <= '0;
         r_streak <= '0;
         r_tick   <= 1'b0;
         r_locked <= 1'b0;
         r_fault  <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_hcount <= w_hcount_nxt;
         r_streak <= w_streak_nxt;
         r_tick   <= w_rise;
         r_locked <= (w_next == ST_LOCKED);
         r_fault  <= w_fault_nxt;
      end
   end

   assign tick   = r_tick;
   assign locked = r_locked;
   assign fault  = r_fault;

`ifdef CLOCK_MONITOR_PERIOD_EN
   logic [CW-1:0] r_lo_half, r_period;

   // half measured at the falling edge pairs with the one closed by the next rise
   always_ff @(posedge clksrc or negedge rst_n) begin
      if (!rst_n) begin
         r_lo_half <= '0;
         r_period  <= '0;
      end else begin
         if (w_fall) r_lo_half <= r_hcount;
         if (w_rise) r_period  <= (r_state == ST_SEARCH) ? '0 : r_lo_half + r_hcount;
      end
   end

   assign period = r_period;
`else
   assign period = '0;
`endif

endmodule

// File: tb/tb_clock_monitor.sv
// Directed bench for clock_monitor with THRESHOLD=8, TOL=1, LOCK_COUNT=4.
module tb_clock_monitor;

`ifdef CLOCK_MONITOR_PERIOD_EN
   localparam bit PEN = 1'b1;
`else
   localparam bit PEN = 1'b0;
`endif

   logic        clksrc, rst_n, clk_in;
   logic        tick, locked, fault;
   logic [31:0] period;
   logic        lvl;
   int          total, bad;
   int          fault_cnt, tick_cnt;

   clock_monitor #(.THRESHOLD(8), .TOL(1), .LOCK_COUNT(4), .CW(32)) dut (
      .clksrc (clksrc),
      .rst_n  (rst_n),
      .clk_in (clk_in),
      .tick   (tick),
      .locked (locked),
      .fault  (fault),
      .period (period)
   );

   initial begin
      clksrc = 1'b0;
      forever #5 clksrc = ~clksrc;
   end

   always @(negedge clksrc) begin
      if (fault === 1'b1) fault_cnt <= fault_cnt + 1;
      if (tick === 1'b1)  tick_cnt  <= tick_cnt + 1;
   end

   function automatic logic [31:0] ep(input int v);
      return PEN ? 32'(v) : 32'd0;
   endfunction

   task automatic steps(input int n);
      repeat (n) begin
         @(posedge clksrc);
         #1;
      end
   endtask

   task automatic toggle_now();
      lvl    = ~lvl;
      clk_in = lvl;
   endtask

   task automatic drive_half(input int len);
      toggle_now();
      steps(len);
   endtask

   // starts a half of 8 whose edge completes lock; locked must appear exactly at k+2
   task automatic lock_half(input string nm);
      toggle_now();
      steps(2);
      total++;
      if (locked !== 1'b0) begin bad++; $display("FAIL %s_early locked=%b exp=0", nm, locked); end
      steps(1);
      total++;
      if (locked !== 1'b1) begin bad++; $display("FAIL %s_lock locked=%b exp=1", nm, locked); end
      steps(5);
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      clk_in = 1'b0;
      lvl    = 1'b0;
      steps(3);
      total++;
      if (tick !== 1'b0)    begin bad++; $display("FAIL rst_tick got=%b exp=0", tick); end
      total++;
      if (locked !== 1'b0)  begin bad++; $display("FAIL rst_locked got=%b exp=0", locked); end
      total++;
      if (fault !== 1'b0)   begin bad++; $display("FAIL rst_fault got=%b exp=0", fault); end
      total++;
      if (period !== 32'd0) begin bad++; $display("FAIL rst_period got=%0d exp=0", period); end
      #3 rst_n = 1'b1;
      steps(3);
   endtask

   task automatic test_tick();
      int t0;
      toggle_now();
      steps(1);
      total++;
      if (tick !== 1'b0) begin bad++; $display("FAIL tick_k got=%b exp=0", tick); end
      steps(1);
      total++;
      if (tick !== 1'b0) begin bad++; $display("FAIL tick_k1 got=%b exp=0", tick); end
      steps(1);
      total++;
      if (tick !== 1'b1) begin bad++; $display("FAIL tick_k2 got=%b exp=1", tick); end
      steps(1);
      total++;
      if (tick !== 1'b0) begin bad++; $display("FAIL tick_k3 got=%b exp=0", tick); end
      steps(4);
      t0 = tick_cnt;
      drive_half(8);
      total++;
      if (tick_cnt != t0) begin bad++; $display("FAIL tick_fall got=%0d pulses exp=0", tick_cnt - t0); end
      total++;
      if (period !== 32'd0) begin bad++; $display("FAIL period_first got=%0d exp=0", period); end
   endtask

   task automatic test_lock();
      int f0;
      f0 = fault_cnt;
      drive_half(8);
      total++;
      if (period !== ep(16)) begin bad++; $display("FAIL period_16 got=%0d exp=%0d", period, ep(16)); end
      drive_half(8);
      lock_half("lock");
      drive_half(8);
      drive_half(8);
      total++;
      if (locked !== 1'b1) begin bad++; $display("FAIL lock_hold got=%b exp=1", locked); end
      total++;
      if (fault_cnt != f0) begin bad++; $display("FAIL lock_fault got=%0d exp=0", fault_cnt - f0); end
   endtask

   task automatic test_tolerance();
      int f0;
      f0 = fault_cnt;
      drive_half(9);
      drive_half(7);
      total++;
      if (period !== ep(17)) begin bad++; $display("FAIL period_17 got=%0d exp=%0d", period, ep(17)); end
      drive_half(8);
      drive_half(8);
      total++;
      if (period !== ep(15)) begin bad++; $display("FAIL period_15 got=%0d exp=%0d", period, ep(15)); end
      total++;
      if (locked !== 1'b1) begin bad++; $display("FAIL tol_locked got=%b exp=1", locked); end
      total++;
      if (fault_cnt != f0) begin bad++; $display("FAIL tol_fault got=%0d exp=0", fault_cnt - f0); end
   endtask

   task automatic test_bad_edge();
      int f0;
      f0 = fault_cnt;
      drive_half(6);
      toggle_now();
      steps(2);
      total++;
      if (locked !== 1'b1) begin bad++; $display("FAIL short_pre got=%b exp=1", locked); end
      steps(1);
      total++;
      if (locked !== 1'b0) begin bad++; $display("FAIL short_drop got=%b exp=0", locked); end
      steps(5);
      drive_half(8);
      drive_half(8);
      drive_half(8);
      lock_half("short_relock");
      total++;
      if (fault_cnt != f0 + 1) begin bad++; $display("FAIL short_fault got=%0d exp=1", fault_cnt - f0); end
   endtask

   task automatic test_long_half();
      int f0;
      f0 = fault_cnt;
      drive_half(10);
      drive_half(8);
      total++;
      if (locked !== 1'b0) begin bad++; $display("FAIL long_drop got=%b exp=0", locked); end
      drive_half(8);
      drive_half(8);
      drive_half(8);
      lock_half("long_relock");
      total++;
      if (fault_cnt != f0 + 1) begin bad++; $display("FAIL long_fault got=%0d exp=1", fault_cnt - f0); end
   endtask

   task automatic test_stall();
      int f0;
      f0 = fault_cnt;
      toggle_now();
      steps(11);
      total++;
      if (fault !== 1'b0) begin bad++; $display("FAIL stall_early got=%b exp=0", fault); end
      steps(1);
      total++;
      if (fault !== 1'b1) begin bad++; $display("FAIL stall_pulse got=%b exp=1", fault); end
      total++;
      if (locked !== 1'b0) begin bad++; $display("FAIL stall_locked got=%b exp=0", locked); end
      steps(20);
      total++;
      if (fault_cnt != f0 + 1) begin bad++; $display("FAIL stall_once got=%0d exp=1", fault_cnt - f0); end
      drive_half(8);
      drive_half(8);
      drive_half(8);
      drive_half(8);
      lock_half("stall_relock");
   endtask

   task automatic test_async_reset();
      #3 rst_n = 1'b0;
      #1;
      total++;
      if (locked !== 1'b0)  begin bad++; $display("FAIL arst_locked got=%b exp=0", locked); end
      total++;
      if (tick !== 1'b0)    begin bad++; $display("FAIL arst_tick got=%b exp=0", tick); end
      total++;
      if (fault !== 1'b0)   begin bad++; $display("FAIL arst_fault got=%b exp=0", fault); end
      total++;
      if (period !== 32'd0) begin bad++; $display("FAIL arst_period got=%0d exp=0", period); end
      lvl    = 1'b0;
      clk_in = 1'b0;
      steps(2);
      #3 rst_n = 1'b1;
      steps(3);
      drive_half(8);
      drive_half(8);
      total++;
      if (period !== 32'd0) begin bad++; $display("FAIL arst_period_search got=%0d exp=0", period); end
      drive_half(8);
      drive_half(8);
      lock_half("arst_relock");
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      fault_cnt = 0;
      tick_cnt  = 0;
      test_reset();
      test_tick();
      test_lock();
      test_tolerance();
      test_bad_edge();
      test_long_half();
      test_stall();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
